// File: rtl/csi_packet_ctrl.sv
// CSI-2 packet sequencer: decodes headers from the header finder, emits the
// byte-aligned payload stream, extracts the CRC footer and raises sync strobes.
module csi_packet_ctrl #(
  parameter logic [15:0] MAX_WC = 16'd4096
) (
  input  logic        rxbyteclkhs,
  input  logic        reset_n,
  input  logic [31:0] ph_in,
  input  logic        ph_in_valid,
  input  logic        ph_select,
  output logic [1:0]  pkt_vc,
  output logic [5:0]  pkt_dt,
  output logic [15:0] pkt_wc,
  output logic [7:0]  pkt_ecc,
  output logic        hdr_valid,
  output logic [15:0] payload_data,
  output logic [1:0]  payload_be,
  output logic        payload_valid,
  output logic        payload_last,
  output logic [15:0] crc_out,
  output logic        crc_valid,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic        in_frame,
  output logic        pkt_error
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CRC_HI, DRAIN} state_t;

  state_t      state_reg;
  logic [15:0] remaining_reg;
  logic [7:0]  crc_lo_reg;

  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;

  assign hdr_dt = ph_in[5:0];
  assign hdr_wc = ph_in[23:8];

  always_ff @(posedge rxbyteclkhs or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      remaining_reg <= 16'd0;
      crc_lo_reg    <= 8'd0;
      pkt_vc        <= 2'd0;
      pkt_dt        <= 6'd0;
      pkt_wc        <= 16'd0;
      pkt_ecc       <= 8'd0;
      hdr_valid     <= 1'b0;
      payload_data  <= 16'd0;
      payload_be    <= 2'b00;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      crc_out       <= 16'd0;
      crc_valid     <= 1'b0;
      frame_start   <= 1'b0;
      frame_end     <= 1'b0;
      line_start    <= 1'b0;
      line_end      <= 1'b0;
      in_frame      <= 1'b0;
      pkt_error     <= 1'b0;
    end else begin
      hdr_valid     <= 1'b0;
      payload_be    <= 2'b00;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      crc_valid     <= 1'b0;
      frame_start   <= 1'b0;
      frame_end     <= 1'b0;
      line_start    <= 1'b0;
      line_end      <= 1'b0;
      pkt_error     <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (ph_in_valid && ph_select) begin
            pkt_vc    <= ph_in[7:6];
            pkt_dt    <= hdr_dt;
            pkt_wc    <= hdr_wc;
            pkt_ecc   <= ph_in[31:24];
            hdr_valid <= 1'b1;
            if (hdr_dt < 6'h10) begin
              case (hdr_dt)
                6'h00: begin frame_start <= 1'b1; in_frame <= 1'b1; end
                6'h01: begin frame_end   <= 1'b1; in_frame <= 1'b0; end
                6'h02: line_start <= 1'b1;
                6'h03: line_end   <= 1'b1;
                default: ;
              endcase
              state_reg <= DRAIN;
            end else if (hdr_wc > MAX_WC) begin
              pkt_error <= 1'b1;
              state_reg <= DRAIN;
            end else begin
              // WC = 0 goes through PAYLOAD too; remaining = 0 means "CRC next"
              remaining_reg <= hdr_wc;
              state_reg     <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (!ph_in_valid) begin
            pkt_error <= 1'b1;
            state_reg <= IDLE;
          end else if (remaining_reg >= 16'd2) begin
            payload_data  <= ph_in[31:16];
            payload_be    <= 2'b11;
            payload_valid <= 1'b1;
            payload_last  <= (remaining_reg == 16'd2);
            remaining_reg <= remaining_reg - 16'd2;
          end else if (remaining_reg == 16'd1) begin
            // odd WC: the upper byte of this word is already the CRC low byte
            payload_data  <= {8'h00, ph_in[23:16]};
            payload_be    <= 2'b01;
            payload_valid <= 1'b1;
            payload_last  <= 1'b1;
            crc_lo_reg    <= ph_in[31:24];
            remaining_reg <= 16'd0;
            state_reg     <= CRC_HI;
          end else begin
            crc_out   <= ph_in[31:16];
            crc_valid <= 1'b1;
            state_reg <= DRAIN;
          end
        end

        CRC_HI: begin
          if (!ph_in_valid) begin
            pkt_error <= 1'b1;
            state_reg <= IDLE;
          end else begin
            crc_out   <= {ph_in[23:16], crc_lo_reg};
            crc_valid <= 1'b1;
            state_reg <= DRAIN;
          end
        end

        DRAIN: begin
          if (!ph_in_valid) state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csi_packet_ctrl.sv
// Directed bench for csi_packet_ctrl: short/long packets, CRC extraction,
// truncation, oversize and asynchronous reset.
module tb_csi_packet_ctrl;

  logic        rxbyteclkhs;
  logic        reset_n;
  logic [31:0] ph_in;
  logic        ph_in_valid;
  logic        ph_select;
  logic [1:0]  pkt_vc;
  logic [5:0]  pkt_dt;
  logic [15:0] pkt_wc;
  logic [7:0]  pkt_ecc;
  logic        hdr_valid;
  logic [15:0] payload_data;
  logic [1:0]  payload_be;
  logic        payload_valid;
  logic        payload_last;
  logic [15:0] crc_out;
  logic        crc_valid;
  logic        frame_start;
  logic        frame_end;
  logic        line_start;
  logic        line_end;
  logic        in_frame;
  logic        pkt_error;

  int compared;
  int mismatched;

  csi_packet_ctrl #(.MAX_WC(16'd4096)) dut (
    .rxbyteclkhs   (rxbyteclkhs),
    .reset_n       (reset_n),
    .ph_in         (ph_in),
    .ph_in_valid   (ph_in_valid),
    .ph_select     (ph_select),
    .pkt_vc        (pkt_vc),
    .pkt_dt        (pkt_dt),
    .pkt_wc        (pkt_wc),
    .pkt_ecc       (pkt_ecc),
    .hdr_valid     (hdr_valid),
    .payload_data  (payload_data),
    .payload_be    (payload_be),
    .payload_valid (payload_valid),
    .payload_last  (payload_last),
    .crc_out       (crc_out),
    .crc_valid     (crc_valid),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .line_start    (line_start),
    .line_end      (line_end),
    .in_frame      (in_frame),
    .pkt_error     (pkt_error)
  );

  initial rxbyteclkhs = 1'b0;
  always #5 rxbyteclkhs = ~rxbyteclkhs;

  // Apply one input word, then move to 1 time unit after the next rising edge,
  // where the outputs reflect exactly that word.
  task automatic drive(input logic v, input logic sel, input logic [31:0] w);
    ph_in_valid = v;
    ph_select   = sel;
    ph_in       = w;
    @(posedge rxbyteclkhs);
    #1;
  endtask

  function automatic logic [31:0] hdr(input logic [7:0] di, input logic [15:0] wc,
                                      input logic [7:0] ecc);
    return {ecc, wc, di};
  endfunction

  function automatic logic [31:0] dat(input logic [7:0] first, input logic [7:0] second);
    return {second, first, 16'h0000};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    ph_in_valid = 1'b0; ph_select = 1'b0; ph_in = 32'h0;
    #12;
    compared++;
    if ({hdr_valid, payload_valid, payload_last, crc_valid, frame_start, frame_end,
         line_start, line_end, in_frame, pkt_error} !== 10'b0) begin
      mismatched++;
      $display("FAIL reset_flags: got %b expected 0", {hdr_valid, payload_valid, payload_last,
               crc_valid, frame_start, frame_end, line_start, line_end, in_frame, pkt_error});
    end
    compared++;
    if ({pkt_vc, pkt_dt, pkt_wc, pkt_ecc, crc_out, payload_data, payload_be} !== 66'b0) begin
      mismatched++;
      $display("FAIL reset_fields: got vc=%h dt=%h wc=%h ecc=%h crc=%h data=%h be=%b expected 0",
               pkt_vc, pkt_dt, pkt_wc, pkt_ecc, crc_out, payload_data, payload_be);
    end
    @(negedge rxbyteclkhs);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    $display("reset: done");
  endtask

  task automatic test_short_sync();
    drive(1'b1, 1'b1, hdr(8'h00, 16'h0001, 8'h07));
    compared++;
    if ({hdr_valid, frame_start, in_frame, payload_valid} !== 4'b1110 ||
        pkt_dt !== 6'h00 || pkt_wc !== 16'h0001 || pkt_ecc !== 8'h07) begin
      mismatched++;
      $display("FAIL fs_header: got hv/fs/if/pv=%b dt=%h wc=%h ecc=%h expected 1110 00 0001 07",
               {hdr_valid, frame_start, in_frame, payload_valid}, pkt_dt, pkt_wc, pkt_ecc);
    end
    drive(1'b0, 1'b0, 32'h0);
    compared++;
    if ({hdr_valid, frame_start, in_frame, pkt_error} !== 4'b0010) begin
      mismatched++;
      $display("FAIL fs_after: got hv/fs/if/err=%b expected 0010",
               {hdr_valid, frame_start, in_frame, pkt_error});
    end
    // Line start on VC 3
    drive(1'b1, 1'b1, hdr(8'hC2, 16'h0005, 8'h11));
    compared++;
    if ({line_start, line_end, frame_start, frame_end} !== 4'b1000 || pkt_vc !== 2'd3 ||
        pkt_dt !== 6'h02 || pkt_wc !== 16'h0005) begin
      mismatched++;
      $display("FAIL ls: got ls/le/fs/fe=%b vc=%0d dt=%h wc=%h expected 1000 3 02 0005",
               {line_start, line_end, frame_start, frame_end}, pkt_vc, pkt_dt, pkt_wc);
    end
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, hdr(8'h03, 16'h0005, 8'h12));
    compared++;
    if ({line_start, line_end} !== 2'b01) begin
      mismatched++;
      $display("FAIL le: got ls/le=%b expected 01", {line_start, line_end});
    end
    drive(1'b0, 1'b0, 32'h0);
    // Generic short packet: header strobe only
    drive(1'b1, 1'b1, hdr(8'h08, 16'h1234, 8'h13));
    compared++;
    if ({hdr_valid, frame_start, frame_end, line_start, line_end, in_frame} !== 6'b100001) begin
      mismatched++;
      $display("FAIL generic_short: got %b expected 100001",
               {hdr_valid, frame_start, frame_end, line_start, line_end, in_frame});
    end
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, hdr(8'h01, 16'h0001, 8'h14));
    compared++;
    if ({frame_end, in_frame, hdr_valid} !== 3'b101) begin
      mismatched++;
      $display("FAIL fe: got fe/if/hv=%b expected 101", {frame_end, in_frame, hdr_valid});
    end
    drive(1'b0, 1'b0, 32'h0);
    $display("short_sync: done");
  endtask

  task automatic test_long_even();
    drive(1'b1, 1'b1, hdr(8'h2A, 16'd4, 8'h15));
    compared++;
    if (hdr_valid !== 1'b1 || pkt_dt !== 6'h2A || pkt_wc !== 16'd4 || payload_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL even_hdr: got hv=%b dt=%h wc=%0d pv=%b expected 1 2a 4 0",
               hdr_valid, pkt_dt, pkt_wc, payload_valid);
    end
    drive(1'b1, 1'b0, dat(8'h11, 8'h22));
    compared++;
    if (payload_valid !== 1'b1 || payload_data !== 16'h2211 || payload_be !== 2'b11 ||
        payload_last !== 1'b0) begin
      mismatched++;
      $display("FAIL even_w0: got pv=%b d=%h be=%b last=%b expected 1 2211 11 0",
               payload_valid, payload_data, payload_be, payload_last);
    end
    drive(1'b1, 1'b0, dat(8'h33, 8'h44));
    compared++;
    if (payload_valid !== 1'b1 || payload_data !== 16'h4433 || payload_be !== 2'b11 ||
        payload_last !== 1'b1 || crc_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL even_w1: got pv=%b d=%h be=%b last=%b cv=%b expected 1 4433 11 1 0",
               payload_valid, payload_data, payload_be, payload_last, crc_valid);
    end
    drive(1'b1, 1'b0, dat(8'hAA, 8'hBB));
    compared++;
    if (crc_valid !== 1'b1 || crc_out !== 16'hBBAA || payload_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL even_crc: got cv=%b crc=%h pv=%b expected 1 bbaa 0",
               crc_valid, crc_out, payload_valid);
    end
    drive(1'b0, 1'b0, 32'h0);
    compared++;
    if (crc_valid !== 1'b0 || pkt_error !== 1'b0 || crc_out !== 16'hBBAA) begin
      mismatched++;
      $display("FAIL even_end: got cv=%b err=%b crc=%h expected 0 0 bbaa",
               crc_valid, pkt_error, crc_out);
    end
    $display("long_even: done");
  endtask

  task automatic test_long_odd();
    drive(1'b1, 1'b1, hdr(8'h2A, 16'd3, 8'h16));
    drive(1'b1, 1'b0, dat(8'h11, 8'h22));
    compared++;
    if (payload_valid !== 1'b1 || payload_data !== 16'h2211 || payload_be !== 2'b11 ||
        payload_last !== 1'b0) begin
      mismatched++;
      $display("FAIL odd_w0: got pv=%b d=%h be=%b last=%b expected 1 2211 11 0",
               payload_valid, payload_data, payload_be, payload_last);
    end
    drive(1'b1, 1'b0, dat(8'h33, 8'hAA));
    compared++;
    if (payload_valid !== 1'b1 || payload_data !== 16'h0033 || payload_be !== 2'b01 ||
        payload_last !== 1'b1 || crc_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL odd_w1: got pv=%b d=%h be=%b last=%b cv=%b expected 1 0033 01 1 0",
               payload_valid, payload_data, payload_be, payload_last, crc_valid);
    end
    drive(1'b1, 1'b0, dat(8'hBB, 8'h5A));
    compared++;
    if (crc_valid !== 1'b1 || crc_out !== 16'hBBAA || payload_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL odd_crc: got cv=%b crc=%h pv=%b expected 1 bbaa 0",
               crc_valid, crc_out, payload_valid);
    end
    drive(1'b0, 1'b0, 32'h0);
    $display("long_odd: done");
  endtask

  task automatic test_wc_zero();
    drive(1'b1, 1'b1, hdr(8'h2A, 16'd0, 8'h17));
    drive(1'b1, 1'b0, dat(8'hCC, 8'hDD));
    compared++;
    if (crc_valid !== 1'b1 || crc_out !== 16'hDDCC || payload_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL wc0_crc: got cv=%b crc=%h pv=%b expected 1 ddcc 0",
               crc_valid, crc_out, payload_valid);
    end
    drive(1'b0, 1'b0, 32'h0);
    $display("wc_zero: done");
  endtask

  task automatic test_truncation();
    int words;
    words = 0;
    drive(1'b1, 1'b1, hdr(8'h2B, 16'd8, 8'h18));
    drive(1'b1, 1'b0, dat(8'h01, 8'h02));
    if (payload_valid === 1'b1) words++;
    drive(1'b1, 1'b0, dat(8'h03, 8'h04));
    if (payload_valid === 1'b1) words++;
    compared++;
    if (words !== 2 || payload_data !== 16'h0403) begin
      mismatched++;
      $display("FAIL trunc_words: got %0d words last=%h expected 2 0403", words, payload_data);
    end
    drive(1'b0, 1'b0, 32'h0);
    compared++;
    if (pkt_error !== 1'b1 || crc_valid !== 1'b0 || payload_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL trunc_err: got err=%b cv=%b pv=%b expected 1 0 0",
               pkt_error, crc_valid, payload_valid);
    end
    drive(1'b1, 1'b1, hdr(8'h00, 16'h0002, 8'h19));
    compared++;
    if (hdr_valid !== 1'b1 || frame_start !== 1'b1 || pkt_wc !== 16'h0002 || pkt_error !== 1'b0) begin
      mismatched++;
      $display("FAIL trunc_next: got hv=%b fs=%b wc=%h err=%b expected 1 1 0002 0",
               hdr_valid, frame_start, pkt_wc, pkt_error);
    end
    drive(1'b0, 1'b0, 32'h0);
    $display("truncation: done");
  endtask

  task automatic test_oversize();
    int pv_seen;
    pv_seen = 0;
    drive(1'b1, 1'b1, hdr(8'h2A, 16'd4097, 8'h1A));
    compared++;
    if (pkt_error !== 1'b1 || hdr_valid !== 1'b1 || pkt_wc !== 16'd4097) begin
      mismatched++;
      $display("FAIL over_err: got err=%b hv=%b wc=%0d expected 1 1 4097",
               pkt_error, hdr_valid, pkt_wc);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, dat(8'h55, 8'h66));
      if (payload_valid === 1'b1 || crc_valid === 1'b1) pv_seen++;
    end
    drive(1'b0, 1'b0, 32'h0);
    compared++;
    if (pv_seen !== 0 || pkt_error !== 1'b0) begin
      mismatched++;
      $display("FAIL over_drain: got %0d data/crc cycles err=%b expected 0 0", pv_seen, pkt_error);
    end
    // Exactly MAX_WC is legal
    drive(1'b1, 1'b1, hdr(8'h2A, 16'd4096, 8'h1B));
    drive(1'b1, 1'b0, dat(8'h77, 8'h88));
    compared++;
    if (pkt_error !== 1'b0 || payload_valid !== 1'b1 || payload_data !== 16'h8877) begin
      mismatched++;
      $display("FAIL max_wc: got err=%b pv=%b d=%h expected 0 1 8877",
               pkt_error, payload_valid, payload_data);
    end
    $display("oversize: done");
  endtask

  task automatic test_reset_mid_packet();
    // Still inside the MAX_WC packet from the previous task; reset asynchronously
    drive(1'b1, 1'b0, dat(8'h99, 8'hAA));
    #2;
    reset_n = 1'b0;
    #1;
    compared++;
    if ({payload_valid, payload_last, pkt_error, in_frame, hdr_valid} !== 5'b0 ||
        payload_data !== 16'h0 || pkt_wc !== 16'h0 || crc_out !== 16'h0 || payload_be !== 2'b00) begin
      mismatched++;
      $display("FAIL rst_mid: got pv/pl/err/if/hv=%b d=%h wc=%h crc=%h be=%b expected 0",
               {payload_valid, payload_last, pkt_error, in_frame, hdr_valid},
               payload_data, pkt_wc, crc_out, payload_be);
    end
    ph_in_valid = 1'b1; ph_select = 1'b0; ph_in = dat(8'h01, 8'h02);
    @(negedge rxbyteclkhs);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, hdr(8'h02, 16'h0009, 8'h1C));
    compared++;
    if (pkt_error !== 1'b0 || hdr_valid !== 1'b1 || line_start !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_after: got err=%b hv=%b ls=%b expected 0 1 1",
               pkt_error, hdr_valid, line_start);
    end
    drive(1'b0, 1'b0, 32'h0);
    $display("reset_mid_packet: done");
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_short_sync();
    test_long_even();
    test_long_odd();
    test_wc_zero();
    test_truncation();
    test_oversize();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/csi_packet_ctrl.md
# csi_packet_ctrl

Sequences the 32-bit packet-header/data stream produced by the packet-header finder in the CSI-2 receive path. Decodes the packet header, classifies short and long packets, tracks the payload byte count, and extracts the 16-bit packet footer (CRC). Emits a byte-aligned payload stream and frame/line synchronisation pulses to the downstream pixel unpacker. Flags truncated and oversize packets.

## Interface
Parameters:
- MAX_WC, 16'd4096: largest legal long-packet word count in bytes; a larger WC is an error.

Ports:
- rxbyteclkhs  in  1  byte clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ph_in  in  32  finder output; header word when ph_select=1, otherwise new data bytes in [31:16] (first byte in [23:16]).
- ph_in_valid  in  1  ph_in valid; deassertion marks end of the lane burst.
- ph_select  in  1  ph_in carries the packet header: DI=[7:0], WC=[23:8], ECC=[31:24].
- pkt_vc  out  2  virtual channel, DI[7:6], held from header until next header.
- pkt_dt  out  6  data type, DI[5:0], held.
- pkt_wc  out  16  word count (long) or frame/line number (short), held.
- pkt_ecc  out  8  received ECC byte, held; not checked here.
- hdr_valid  out  1  1-cycle pulse, header fields updated.
- payload_data  out  16  payload bytes; [7:0] is the earlier byte.
- payload_be  out  2  byte enables for payload_data.
- payload_valid  out  1  payload_data/payload_be valid this cycle.
- payload_last  out  1  with payload_valid, final payload word of the packet.
- crc_out  out  16  received footer, {second byte, first byte}, held.
- crc_valid  out  1  1-cycle pulse, crc_out updated.
- frame_start, frame_end, line_start, line_end  out  1 each  1-cycle pulses for short DT 0x00/0x01/0x02/0x03.
- in_frame  out  1  set by frame_start, cleared by frame_end.
- pkt_error  out  1  1-cycle pulse: truncation or WC > MAX_WC.

## Operation
- States: IDLE, PAYLOAD, CRC_HI, DRAIN.
- IDLE: on ph_in_valid & ph_select, latch header and pulse hdr_valid. Short packet (DT < 0x10): pulse the matching sync strobe (DT 0x04–0x0F: no strobe) -> DRAIN. Long packet: WC > MAX_WC -> pkt_error, DRAIN; WC = 0 -> CRC_LO phase handled in PAYLOAD with remaining = 0; else load remaining = WC -> PAYLOAD.
- PAYLOAD, each valid cycle: remaining >= 2: emit ph_in[31:16], be=2'b11, remaining -= 2; payload_last when remaining becomes 0 -> next cycle's two bytes are CRC (capture both, crc_valid) -> DRAIN. remaining = 1: emit ph_in[23:16], be=2'b01, payload_last; ph_in[31:24] is CRC low byte -> CRC_HI. remaining = 0 (WC=0): cycle's bytes are CRC -> crc_valid, DRAIN.
- CRC_HI: next valid cycle, ph_in[23:16] is CRC high byte; crc_valid -> DRAIN.
- DRAIN: ignore data until ph_in_valid = 0 -> IDLE.
- ph_in_valid = 0 in PAYLOAD or CRC_HI: pkt_error, no crc_valid, no further payload, -> IDLE. Deassertion in IDLE/DRAIN is not an error.
- ph_select = 1 outside IDLE: treated as data (finder only asserts it after a valid gap).
- frame_start while in_frame, or frame_end while not in_frame: strobe still pulses, in_frame follows the strobe; no error.
- remaining is 16 bits; never decrements below 0.

## Timing
- All outputs registered; every output reflects the ph_in cycle one clock earlier (latency 1).
- Header cycle -> hdr_valid and any sync strobe in the same following cycle; the first payload word appears one cycle after hdr_valid.
- Payload throughput: 2 bytes/cycle, no back-pressure; ceil(WC/2) payload_valid cycles per packet.
- Reset (reset_n low, asynchronous): state IDLE; all pulses, payload_valid, payload_last, in_frame = 0; pkt_vc, pkt_dt, pkt_wc, pkt_ecc, crc_out, payload_data = 0; payload_be = 2'b00. Reset mid-packet discards the packet without pkt_error.

## Test plan
- Short FS: header DI=0x00, WC=0x0001, ECC=0x07, then deassert -> hdr_valid, frame_start, in_frame=1, no payload; FE (DI=0x01) -> frame_end, in_frame=0.
- Long even: DI=0x2A, WC=4, data 11 22 33 44, CRC AA BB -> payload 0x2211 be=11, 0x4433 be=11 last; crc_out=0xBBAA, crc_valid one cycle after last.
- Long odd: WC=3, data 11 22 33, CRC AA BB -> 0x2211 be=11, 0x0033 be=01 last; crc_out=0xBBAA after CRC_HI.
- WC=0 long: CRC CC DD in first data cycle -> no payload_valid, crc_out=0xDDCC.
- Truncation: WC=8, ph_in_valid drops after 2 data cycles -> 2 payload words, pkt_error pulse, no crc_valid, back in IDLE; next header decoded normally.
- Oversize and reset: WC=MAX_WC+1 -> pkt_error, no payload; reset_n low mid-PAYLOAD -> all outputs 0 immediately, no pkt_error.
